iterative_shifter: RTL and testbench
====================================

ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 Parameter SHIFT_AMOUNT_WIDTH, default $clog2(DATA_WIDTH), shift-amount width.
REQ-003 Parameter STEP, default 1, maximum bits shifted per cycle; power of two, 1..DATA_WIDTH.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 data  input  DATA_WIDTH  operand.
REQ-009 shift_amount  input  SHIFT_AMOUNT_WIDTH  shift count, 0..DATA_WIDTH-1.
REQ-010 shift_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result  output  DATA_WIDTH  shifted/rotated value.
REQ-014 out_err  output  1  high with out_valid when the request used an illegal shift_op.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-017 Request SHALL be accepted on a rising edge where in_valid && in_ready; data, shift_amount, shift_op captured; later input changes ignored.
REQ-018 in_ready SHALL be high in IDLE, and in DONE when out_ready is high (back-to-back acceptance); low otherwise.
REQ-019 On accept, next state SHALL be DONE if shift_amount==0 or op illegal, else SHIFT with remaining=shift_amount.
REQ-020 In SHIFT each cycle SHALL apply k=min(STEP, remaining) bits of the captured op to the working register and decrement remaining by k; transition to DONE when remaining reaches 0.
REQ-021 SLL/SRL SHALL fill with zeros; SRA SHALL fill with the captured operand MSB; ROL/ROR SHALL wrap bits around; result width always DATA_WIDTH.
REQ-022 Latency from accept edge to out_valid high SHALL be 1+ceil(n/STEP) cycles for legal op with amount n; 1 cycle for n=0 or illegal op.
REQ-023 In DONE, out_valid SHALL be high and result/out_err held stable until out_valid && out_ready.
REQ-024 On handshake in DONE: with a simultaneous new accept, follow REQ-019; otherwise return to IDLE.
REQ-025 Illegal op SHALL produce result=captured data, out_err=1; legal op out_err=0.
REQ-026 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-027 rst SHALL force state IDLE, out_valid=0, out_err=0, busy=0, result=0, remaining=0 on the next edge, overriding any handshake.
REQ-028 rst asserted mid-SHIFT or in DONE SHALL discard the in-flight request; no out_valid for it afterwards.
REQ-029 in_ready SHALL be 0 while rst is high and 1 the first cycle after release.

Structure
REQ-030 Op encodings (SLL..ROR) and FSM state encoding SHALL reside in shared package shifter_pkg.
REQ-031 A single sub-module shift_step SHALL implement the combinational one-step shift/rotate by k (0..STEP) for all five ops; FSM and handshake live in iterative_shifter.

Verification (DATA_WIDTH=8)
REQ-032 STEP=1, SRA data=8'b10001111 amount=3 -> result 8'b11110001, out_valid 4 cycles after accept, out_err=0.
REQ-033 STEP=1, ROL data=8'b10010110 amount=3 -> 8'b10110100; ROR data=8'b00000001 amount=1 -> 8'b10000000 after 2 cycles.
REQ-034 STEP=4, SRL data=8'b11110000 amount=7 -> 8'b00000001 after 3 cycles; SLL amount=0 -> data unchanged after 1 cycle.
REQ-035 shift_op=3'b110, data=8'hA5 -> result 8'hA5, out_err=1, after 1 cycle.
REQ-036 out_ready low 5 cycles in DONE -> result stable, in_ready low; then out_ready high with in_valid high -> new request accepted same edge.
REQ-037 rst pulse during SHIFT (amount=7, STEP=1, cycle 3) -> next edge IDLE, out_valid 0, no stale result emitted.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Codes 101..111 are reserved and reported as errors.
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step: shift or rotate the working value by k bits (0..STEP).
module shift_step
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STEP       = 1,
  parameter int K_WIDTH    = $clog2(STEP + 1)
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [K_WIDTH-1:0]    k,
  input  logic [2:0]            op,
  input  logic                  fill,
  output logic [DATA_WIDTH-1:0] data_out
);

  int unsigned amt;
  int unsigned back;
  logic [DATA_WIDTH-1:0] fill_mask;

  always_comb begin
    amt  = 32'(k);
    back = 32'(DATA_WIDTH) - amt;
    // Top amt bits set; SRA fills with the operand sign captured at accept.
    fill_mask = fill ? ~({DATA_WIDTH{1'b1}} >> amt) : '0;
    data_out  = data_in;
    case (op)
      OP_SLL:  data_out = data_in << amt;
      OP_SRL:  data_out = data_in >> amt;
      OP_SRA:  data_out = (data_in >> amt) | fill_mask;
      OP_ROL:  data_out = (data_in << amt) | (data_in >> back);
      OP_ROR:  data_out = (data_in >> amt) | (data_in << back);
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter/rotator: applies up to STEP bits per cycle under a
// valid/ready request interface and a valid/ready result interface.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int SHIFT_AMOUNT_WIDTH = $clog2(DATA_WIDTH),
  parameter int STEP               = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         data,
  input  logic [SHIFT_AMOUNT_WIDTH-1:0] shift_amount,
  input  logic [2:0]                    shift_op,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         result,
  output logic                          out_err,
  output logic                          busy
);

  localparam int K_WIDTH = $clog2(STEP + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload stable while valid is high and ready is low.
  state_e                        state;
  logic [DATA_WIDTH-1:0]         work;
  logic [DATA_WIDTH-1:0]         step_out;
  logic [SHIFT_AMOUNT_WIDTH-1:0] remaining;
  logic [SHIFT_AMOUNT_WIDTH-1:0] rem_next;
  logic [K_WIDTH-1:0]            step_k;
  logic [2:0]                    op_q;
  logic                          fill_q;
  logic                          accept;
  logic                          short_req;

  assign result = work;

  always_comb begin
    in_ready  = !rst && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    accept    = in_valid && in_ready;
    short_req = !op_legal(shift_op) || (shift_amount == '0);
    if (32'(remaining) > STEP) step_k = K_WIDTH'(STEP);
    else                       step_k = K_WIDTH'(remaining);
    rem_next = remaining - SHIFT_AMOUNT_WIDTH'(step_k);
  end

  shift_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP),
    .K_WIDTH    (K_WIDTH)
  ) u_step (
    .data_in  (work),
    .k        (step_k),
    .op       (op_q),
    .fill     (fill_q),
    .data_out (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      work      <= '0;
      remaining <= '0;
      op_q      <= '0;
      fill_q    <= 1'b0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // Accept is only possible from IDLE or from DONE while the result drains.
      work   <= data;
      op_q   <= shift_op;
      fill_q <= data[DATA_WIDTH-1];
      busy   <= 1'b1;
      if (short_req) begin
        state     <= ST_DONE;
        remaining <= '0;
        out_valid <= 1'b1;
        out_err   <= !op_legal(shift_op);
      end else begin
        state     <= ST_SHIFT;
        remaining <= shift_amount;
        out_valid <= 1'b0;
        out_err   <= 1'b0;
      end
    end else begin
      case (state)
        ST_SHIFT: begin
          work      <= step_out;
          remaining <= rem_next;
          if (rem_next == '0) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: STEP=1 and STEP=4 instances share one request
// stream; each has its own expected-result and expected-latency queues.
module tb_iterative_shifter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] data;
  logic [2:0] shift_amount;
  logic [2:0] shift_op;
  logic       out_ready;

  logic       in_ready1, out_valid1, out_err1, busy1;
  logic [7:0] result1;
  logic       in_ready4, out_valid4, out_err4, busy4;
  logic [7:0] result4;

  iterative_shifter #(.DATA_WIDTH(8), .SHIFT_AMOUNT_WIDTH(3), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .data(data), .shift_amount(shift_amount), .shift_op(shift_op),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .out_err(out_err1), .busy(busy1)
  );

  iterative_shifter #(.DATA_WIDTH(8), .SHIFT_AMOUNT_WIDTH(3), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .data(data), .shift_amount(shift_amount), .shift_op(shift_op),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
    .out_err(out_err4), .busy(busy4)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         amt;
    logic [2:0] op;
    logic [7:0] exp_res;
    logic       exp_err;
  } vec_t;

  logic [8:0] exp_q1[$];
  logic [8:0] exp_q4[$];
  int         lat_q1[$];
  int         lat_q4[$];
  int         check_cnt = 0;
  int         pass_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: one bit at a time, SRA fill taken from the original operand.
  function automatic logic [7:0] model(input logic [7:0] d, input int n, input logic [2:0] op);
    logic [7:0] r;
    r = d;
    if (op > 3'd4) return d;
    for (int i = 0; i < n; i++) begin
      case (op)
        3'd0: r = {r[6:0], 1'b0};
        3'd1: r = {1'b0, r[7:1]};
        3'd2: r = {d[7], r[7:1]};
        3'd3: r = {r[6:0], r[7]};
        default: r = {r[0], r[7:1]};
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input int n, input logic [2:0] op, input int step);
    if (op > 3'd4 || n == 0) return 1;
    return 1 + (n + step - 1) / step;
  endfunction

  // Driver: present a request (called #1 after an edge); next edge accepts it.
  task automatic issue(input logic [7:0] d, input int n, input logic [2:0] op,
                       input logic [7:0] er, input logic ee);
    check("in_ready_step1", in_ready1, 1);
    check("in_ready_step4", in_ready4, 1);
    data         = d;
    shift_amount = 3'(n);
    shift_op     = op;
    in_valid     = 1'b1;
    exp_q1.push_back({ee, er});
    exp_q4.push_back({ee, er});
    lat_q1.push_back(exp_lat(n, op, 1));
    lat_q4.push_back(exp_lat(n, op, 4));
  endtask

  // Monitor: wait for both instances to present a result, compare against queues.
  task automatic collect();
    bit d1 = 1'b0;
    bit d4 = 1'b0;
    logic [8:0] e;
    int l;
    for (int c = 1; c <= 40 && !(d1 && d4); c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        in_valid = 1'b0;
        data     = $urandom_range(0, 255);
      end
      if (!d1 && out_valid1) begin
        d1 = 1'b1;
        if (exp_q1.size() == 0) check("unexpected_out_step1", 1, 0);
        else begin
          e = exp_q1.pop_front();
          l = lat_q1.pop_front();
          check("result_step1", result1, e[7:0]);
          check("err_step1", out_err1, e[8]);
          check("latency_step1", c, l);
        end
      end
      if (!d4 && out_valid4) begin
        d4 = 1'b1;
        if (exp_q4.size() == 0) check("unexpected_out_step4", 1, 0);
        else begin
          e = exp_q4.pop_front();
          l = lat_q4.pop_front();
          check("result_step4", result4, e[7:0]);
          check("err_step4", out_err4, e[8]);
          check("latency_step4", c, l);
        end
      end
    end
    if (!d1) check("timeout_step1", 0, 1);
    if (!d4) check("timeout_step4", 0, 1);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    int seen;

    rst          = 1'b1;
    in_valid     = 1'b0;
    data         = '0;
    shift_amount = '0;
    shift_op     = '0;
    out_ready    = 1'b1;

    vecs.push_back('{8'b10001111, 3, 3'b010, 8'b11110001, 1'b0});
    vecs.push_back('{8'b10010110, 3, 3'b011, 8'b10110100, 1'b0});
    vecs.push_back('{8'b00000001, 1, 3'b100, 8'b10000000, 1'b0});
    vecs.push_back('{8'b11110000, 7, 3'b001, 8'b00000001, 1'b0});
    vecs.push_back('{8'h5A,       0, 3'b000, 8'h5A,       1'b0});
    vecs.push_back('{8'hA5,       5, 3'b110, 8'hA5,       1'b1});
    vecs.push_back('{8'h81,       7, 3'b010, 8'hFF,       1'b0});
    vecs.push_back('{8'h81,       7, 3'b000, 8'h80,       1'b0});
    for (int i = 0; i < 12; i++) begin
      v.data    = 8'($urandom_range(0, 255));
      v.amt     = $urandom_range(0, 7);
      v.op      = 3'($urandom_range(0, 7));
      v.exp_res = model(v.data, v.amt, v.op);
      v.exp_err = (v.op > 3'd4);
      vecs.push_back(v);
    end

    // Reset state, and in_ready held low while rst is high
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_step1", in_ready1, 0);
    check("rst_in_ready_step4", in_ready4, 0);
    check("rst_out_valid_step1", out_valid1, 0);
    check("rst_out_valid_step4", out_valid4, 0);
    check("rst_busy_step1", busy1, 0);
    check("rst_result_step1", result1, 0);
    check("rst_result_step4", result4, 0);
    check("rst_err_step1", out_err1, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst_step1", in_ready1, 1);
    check("in_ready_after_rst_step4", in_ready4, 1);

    // Table-driven vectors, issued back to back
    foreach (vecs[i]) begin
      issue(vecs[i].data, vecs[i].amt, vecs[i].op, vecs[i].exp_res, vecs[i].exp_err);
      collect();
    end

    // Output stall: result held, in_ready low, then drain with same-edge accept
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(8'h0F, 2, 3'b000, 8'h3C, 1'b0);
    collect();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_result_step1", result1, 8'h3C);
      check("stall_result_step4", result4, 8'h3C);
      check("stall_in_ready_step1", in_ready1, 0);
      check("stall_in_ready_step4", in_ready4, 0);
      check("stall_valid_step1", out_valid1, 1);
      check("stall_busy_step4", busy4, 1);
    end
    out_ready = 1'b1;
    #1;
    issue(8'h01, 1, 3'b100, 8'h80, 1'b0);
    collect();

    // Reset during SHIFT (STEP=1) and DONE (STEP=4): request must vanish
    @(posedge clk);
    #1;
    out_ready    = 1'b0;
    data         = 8'hFF;
    shift_amount = 3'd7;
    shift_op     = 3'b001;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy_step1", busy1, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid_step1", out_valid1, 0);
    check("mid_rst_valid_step4", out_valid4, 0);
    check("mid_rst_busy_step1", busy1, 0);
    check("mid_rst_busy_step4", busy4, 0);
    check("mid_rst_result_step1", result1, 0);
    check("mid_rst_result_step4", result4, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    seen      = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid1 || out_valid4) seen++;
    end
    check("stale_outputs_after_rst", seen, 0);
    check("idle_in_ready_step1", in_ready1, 1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
